// File: rtl/load_store_unit.sv
// Load/store unit: turns a core load/store into one word-aligned valid/ready bus
// transaction with byte enables, extends load data and stalls the core meanwhile.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_address,
  input  logic [31:0] i_storeData,
  output logic        o_stall,
  output logic [31:0] o_loadData,
  output logic        o_loadValid,
  output logic        o_fault,
  output logic        o_memValid,
  input  logic        i_memReady,
  output logic        o_memWrite,
  output logic [31:0] o_memAddress,
  output logic [3:0]  o_memByteEnable,
  output logic [31:0] o_memWriteData,
  input  logic        i_memRespValid,
  input  logic [31:0] i_memRespData
);

  typedef enum logic [1:0] {IDLE, REQUEST, RESPONSE, DONE} state_e;

  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [9:0]  cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        mem_valid_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        to_fault_q;

  logic        req_s;
  logic        illegal_s;
  logic        timeout_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  // Shift the addressed lane down, then sign- or zero-extend by access size.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extend_load = {24'h000000, sh[7:0]};
      3'b101:  extend_load = {16'h0000, sh[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  assign req_s     = i_memRead | i_memWrite;
  assign timeout_s = (cnt_q == TIMEOUT_LAST);

  // Legality check and lane mapping for the request currently offered in IDLE.
  always_comb begin
    illegal_s = 1'b0;
    be_s      = 4'b0000;
    wdata_s   = i_storeData;
    case (i_funct3)
      3'b000, 3'b100: begin
        illegal_s = i_memWrite & i_funct3[2];
        be_s      = 4'b0001 << i_address[1:0];
        wdata_s   = {4{i_storeData[7:0]}};
      end
      3'b001, 3'b101: begin
        illegal_s = i_address[0] | (i_memWrite & i_funct3[2]);
        be_s      = i_address[1] ? 4'b1100 : 4'b0011;
        wdata_s   = {2{i_storeData[15:0]}};
      end
      3'b010: begin
        illegal_s = |i_address[1:0];
        be_s      = 4'b1111;
        wdata_s   = i_storeData;
      end
      default: begin
        illegal_s = 1'b1;
        be_s      = 4'b0000;
        wdata_s   = i_storeData;
      end
    endcase
    if (i_memRead && i_memWrite) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = illegal_s;
    end
  end

  assign o_stall = ((state_q == IDLE) & req_s & ~illegal_s)
                 | (state_q == REQUEST) | (state_q == RESPONSE);
  assign o_fault = ((state_q == IDLE) & req_s & illegal_s) | to_fault_q;

  assign o_memValid      = mem_valid_q;
  assign o_memWrite      = mem_write_q;
  assign o_memAddress    = mem_addr_q;
  assign o_memByteEnable = mem_be_q;
  assign o_memWriteData  = mem_wdata_q;
  assign o_loadData      = load_data_q;
  assign o_loadValid     = load_valid_q;

  // Transaction FSM with all bus and result outputs registered.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q      <= IDLE;
      cnt_q        <= 10'd0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0000_0000;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
      to_fault_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          load_valid_q <= 1'b0;
          to_fault_q   <= 1'b0;
          if (req_s && !illegal_s) begin
            cnt_q       <= 10'd0;
            funct3_q    <= i_funct3;
            lane_q      <= i_address[1:0];
            mem_valid_q <= 1'b1;
            mem_write_q <= i_memWrite;
            mem_addr_q  <= {i_address[31:2], 2'b00};
            mem_be_q    <= be_s;
            mem_wdata_q <= wdata_s;
            state_q     <= REQUEST;
          end
        end
        REQUEST: begin
          // A handshake on the last allowed cycle still completes normally.
          if (i_memReady) begin
            mem_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 10'd1;
            state_q     <= mem_write_q ? DONE : RESPONSE;
          end else if (timeout_s) begin
            mem_valid_q <= 1'b0;
            to_fault_q  <= 1'b1;
            load_data_q <= 32'h0000_0000;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        RESPONSE: begin
          if (i_memRespValid) begin
            load_data_q  <= extend_load(funct3_q, lane_q, i_memRespData);
            load_valid_q <= 1'b1;
            state_q      <= DONE;
          end else if (timeout_s) begin
            to_fault_q  <= 1'b1;
            load_data_q <= 32'h0000_0000;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        DONE: begin
          load_valid_q <= 1'b0;
          load_data_q  <= 32'h0000_0000;
          to_fault_q   <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          mem_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; a second instance with TIMEOUT_CYCLES=4
// shares the inputs and covers the timeout abort.
module tb_load_store_unit;

  logic        clk;
  logic        arst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        mem_ready;
  logic        resp_valid;
  logic [31:0] resp_data;

  logic        stall, load_valid, fault, m_valid, m_write;
  logic [31:0] load_data, m_addr, m_wdata;
  logic [3:0]  m_be;

  logic        stall4, load_valid4, fault4, m_valid4, m_write4;
  logic [31:0] load_data4, m_addr4, m_wdata4;
  logic [3:0]  m_be4;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit dut (
    .i_clk(clk), .i_arst(arst), .i_memRead(mem_read), .i_memWrite(mem_write),
    .i_funct3(funct3), .i_address(address), .i_storeData(store_data),
    .o_stall(stall), .o_loadData(load_data), .o_loadValid(load_valid),
    .o_fault(fault), .o_memValid(m_valid), .i_memReady(mem_ready),
    .o_memWrite(m_write), .o_memAddress(m_addr), .o_memByteEnable(m_be),
    .o_memWriteData(m_wdata), .i_memRespValid(resp_valid), .i_memRespData(resp_data)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut4 (
    .i_clk(clk), .i_arst(arst), .i_memRead(mem_read), .i_memWrite(mem_write),
    .i_funct3(funct3), .i_address(address), .i_storeData(store_data),
    .o_stall(stall4), .o_loadData(load_data4), .o_loadValid(load_valid4),
    .o_fault(fault4), .o_memValid(m_valid4), .i_memReady(mem_ready),
    .o_memWrite(m_write4), .o_memAddress(m_addr4), .o_memByteEnable(m_be4),
    .o_memWriteData(m_wdata4), .i_memRespValid(resp_valid), .i_memRespData(resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    address    = 32'h0;
    store_data = 32'h0;
  endtask

  // Full load with ready on the first REQUEST cycle and response on the first RESPONSE cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    mem_read = 1'b1; funct3 = f3; address = addr;
    #1;
    chk_eq({tag, " idle stall"}, 32'(stall), 32'd1);
    chk_eq({tag, " idle fault"}, 32'(fault), 32'd0);
    tick();
    chk_eq({tag, " req valid"}, 32'(m_valid), 32'd1);
    chk_eq({tag, " req addr"}, m_addr, {addr[31:2], 2'b00});
    chk_eq({tag, " req be"}, 32'(m_be), 32'(exp_be));
    chk_eq({tag, " req write"}, 32'(m_write), 32'd0);
    chk_eq({tag, " req stall"}, 32'(stall), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_eq({tag, " resp valid"}, 32'(m_valid), 32'd0);
    chk_eq({tag, " resp stall"}, 32'(stall), 32'd1);
    resp_valid = 1'b1; resp_data = word;
    tick();
    resp_valid = 1'b0;
    idle_inputs();
    chk_eq({tag, " done stall"}, 32'(stall), 32'd0);
    chk_eq({tag, " done lvalid"}, 32'(load_valid), 32'd1);
    chk_eq({tag, " done data"}, load_data, exp_data);
    tick();
    chk_eq({tag, " back lvalid"}, 32'(load_valid), 32'd0);
  endtask

  // Illegal request: same-cycle fault, no stall, and still no bus request a cycle later.
  task automatic do_fault(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr);
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; store_data = 32'h1234_5678;
    #1;
    chk_eq({tag, " fault"}, 32'(fault), 32'd1);
    chk_eq({tag, " stall"}, 32'(stall), 32'd0);
    tick();
    chk_eq({tag, " no valid"}, 32'(m_valid), 32'd0);
    idle_inputs();
    tick();
    chk_eq({tag, " fault gone"}, 32'(fault), 32'd0);
  endtask

  initial begin
    arst = 1'b1; mem_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
    idle_inputs();
    tick();
    chk_eq("rst stall", 32'(stall), 32'd0);
    chk_eq("rst valid", 32'(m_valid), 32'd0);
    chk_eq("rst addr", m_addr, 32'h0);
    chk_eq("rst fault", 32'(fault), 32'd0);
    arst = 1'b0;
    tick();

    do_load("LW",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("LB",  3'b000, 32'h0000_0203, 32'h80FF_FF12, 4'b1000, 32'hFFFF_FF80);
    do_load("LBU", 3'b100, 32'h0000_0203, 32'h80FF_FF12, 4'b1000, 32'h0000_0080);
    do_load("LH",  3'b001, 32'h0000_0402, 32'h8001_7FFF, 4'b1100, 32'hFFFF_8001);
    do_load("LHU", 3'b101, 32'h0000_0400, 32'h1234_9ABC, 4'b0011, 32'h0000_9ABC);

    // SH with ready low for five REQUEST cycles; DONE lands 7 cycles after IDLE.
    mem_write = 1'b1; funct3 = 3'b001; address = 32'h0000_0302; store_data = 32'h0000_ABCD;
    #1;
    chk_eq("SH idle stall", 32'(stall), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_eq("SH valid", 32'(m_valid), 32'd1);
      chk_eq("SH write", 32'(m_write), 32'd1);
      chk_eq("SH addr", m_addr, 32'h0000_0300);
      chk_eq("SH be", 32'(m_be), 32'h0000_000C);
      chk_eq("SH wdata", m_wdata, 32'hABCD_ABCD);
      chk_eq("SH stall", 32'(stall), 32'd1);
      if (i == 6) mem_ready = 1'b1;
    end
    tick();
    mem_ready = 1'b0;
    idle_inputs();
    chk_eq("SH done stall", 32'(stall), 32'd0);
    chk_eq("SH done valid", 32'(m_valid), 32'd0);
    chk_eq("SH done lvalid", 32'(load_valid), 32'd0);
    chk_eq("SH done fault", 32'(fault), 32'd0);
    tick();

    // SB lane replication and one-hot enable.
    mem_write = 1'b1; funct3 = 3'b000; address = 32'h0000_0011; store_data = 32'hFFFF_FF5A;
    tick();
    chk_eq("SB be", 32'(m_be), 32'h0000_0002);
    chk_eq("SB wdata", m_wdata, 32'h5A5A_5A5A);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    idle_inputs();
    chk_eq("SB done stall", 32'(stall), 32'd0);
    tick();

    do_fault("LW mis",  1'b1, 1'b0, 3'b010, 32'h0000_0101);
    do_fault("SH mis",  1'b0, 1'b1, 3'b001, 32'h0000_0003);
    do_fault("f3 011",  1'b1, 1'b0, 3'b011, 32'h0000_0100);
    do_fault("SBU",     1'b0, 1'b1, 3'b100, 32'h0000_0100);
    do_fault("rd+wr",   1'b1, 1'b1, 3'b010, 32'h0000_0100);

    // Load with no response: dut4 aborts after 4 REQUEST+RESPONSE cycles, dut stays in RESPONSE.
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h0000_0500;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_eq("TO wait stall", 32'(stall4), 32'd1);
      chk_eq("TO wait fault", 32'(fault4), 32'd0);
      tick();
    end
    mem_read = 1'b0;
    chk_eq("TO fault", 32'(fault4), 32'd1);
    chk_eq("TO data", load_data4, 32'h0);
    chk_eq("TO stall", 32'(stall4), 32'd0);
    chk_eq("TO valid", 32'(m_valid4), 32'd0);
    tick();
    chk_eq("TO idle fault", 32'(fault4), 32'd0);
    chk_eq("TO idle stall", 32'(stall4), 32'd0);

    // Asynchronous reset while dut is waiting in RESPONSE; a late response is ignored.
    chk_eq("ARST pre stall", 32'(stall), 32'd1);
    #2 arst = 1'b1;
    #1;
    chk_eq("ARST stall", 32'(stall), 32'd0);
    chk_eq("ARST valid", 32'(m_valid), 32'd0);
    chk_eq("ARST addr", m_addr, 32'h0);
    chk_eq("ARST be", 32'(m_be), 32'd0);
    chk_eq("ARST wdata", m_wdata, 32'h0);
    chk_eq("ARST fault", 32'(fault), 32'd0);
    tick();
    arst = 1'b0;
    tick();
    resp_valid = 1'b1; resp_data = 32'hCAFE_F00D;
    tick();
    resp_valid = 1'b0;
    chk_eq("ARST late lvalid", 32'(load_valid), 32'd0);
    chk_eq("ARST late data", load_data, 32'h0);
    chk_eq("ARST late stall", 32'(stall), 32'd0);
    tick();
    chk_eq("ARST after lvalid", 32'(load_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the single-cycle core's ALU/register-file datapath and an external data memory that uses a valid/ready handshake with variable latency. It converts a core load/store (address, store data, funct3) into one word-aligned bus transaction with byte enables. It sign/zero-extends load data back to 32 bits. It stalls the core (PC and register write) until the transaction completes, faults or times out.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles spent in REQUEST+RESPONSE before abort; range 1..1023.

Ports:
- Clock and reset: one clock (i_clk); reset is asynchronous, active-high (i_arst).
- i_clk  in  1  clock
- i_arst  in  1  asynchronous active-high reset
- i_memRead  in  1  core executes a load (I-type opcode 0000011)
- i_memWrite  in  1  core executes a store (S-type opcode 0100011)
- i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_address  in  32  byte address from ALU (rs1 + imm)
- i_storeData  in  32  rs2 value
- o_stall  out  1  hold PC and suppress regWrite this cycle
- o_loadData  out  32  extended load result, valid while o_loadValid
- o_loadValid  out  1  load result valid (DONE cycle)
- o_fault  out  1  one-cycle pulse: misaligned, illegal funct3, read+write both set, or timeout
- o_memValid  out  1  bus request valid
- i_memReady  in  1  bus accepts request
- o_memWrite  out  1  request is a write
- o_memAddress  out  32  {i_address[31:2], 2'b00}
- o_memByteEnable  out  4  active lanes
- o_memWriteData  out  32  lane-replicated store data
- i_memRespValid  in  1  read data returned
- i_memRespData  in  32  read word

## Operation
- States: IDLE, REQUEST, RESPONSE, DONE. Reset → IDLE; every output 0; timeout counter 0.
- Check (combinational, IDLE only): fault if i_memRead&i_memWrite; funct3 ∉ {000,001,010,100,101} (stores: only 000/001/010); H/HU with address[0]=1; W with address[1:0]≠0.
- IDLE, request and check fails: o_fault=1 same cycle, o_stall=0, no bus activity, stay IDLE.
- IDLE, legal request: o_stall=1; register address, byte enables, write data, funct3 and direction; → REQUEST.
- REQUEST: o_memValid=1; registered bus fields held stable. valid&ready: write → DONE, read → RESPONSE.
- RESPONSE: wait for i_memRespValid, capture extended data → DONE. i_memRespValid outside RESPONSE is ignored.
- DONE: o_stall=0; o_loadValid=1 for reads; core inputs ignored; → IDLE next cycle.
- Timeout: counter clears on leaving IDLE and increments each REQUEST/RESPONSE cycle. At TIMEOUT_CYCLES: drop o_memValid, → DONE with o_fault=1 and o_loadData=0. The memory tolerates request withdrawal.
- Byte enables: B = 1<<addr[1:0]; H = addr[1] ? 1100 : 0011; W = 1111.
- Store data: B = {4{data[7:0]}}; H = {2{data[15:0]}}; W = data.
- Load extraction: select lane by registered addr[1:0]. B/H sign-extend bit 7/15. BU/HU zero-extend.
- o_stall = (IDLE & legal request) | REQUEST | RESPONSE.

## Timing
- o_stall is combinational from inputs in IDLE; all bus outputs and o_loadData/o_loadValid are registered.
- Minimum store: 3 cycles (IDLE, REQUEST with ready, DONE).
- Minimum load: 4 cycles (IDLE, REQUEST, RESPONSE with respValid, DONE).
- Each cycle of ready=0 or respValid=0 adds one cycle.
- Bus fields change only when entering REQUEST; never while o_memValid=1 and ready=0.
- o_fault for a check failure is combinational in IDLE; for a timeout it is registered in DONE.
- Async reset mid-transaction: immediate IDLE, o_memValid=0, o_stall=0. A later i_memRespValid is ignored.
- The core advances PC at the end of the DONE cycle. Back-to-back accesses therefore always separate by one IDLE cycle.

## Test plan
- LW addr 0x100, ready immediate, resp 0xDEADBEEF after 1 cycle → memAddress 0x100, BE 1111, 4-cycle stall pattern 1,1,1,0; loadData 0xDEADBEEF.
- LB addr 0x203 and LBU addr 0x203, resp 0x80FF_FF12 → BE 1000, loadData 0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH addr 0x302, data 0x0000ABCD, ready held low 5 cycles → BE 1100, writeData 0xABCDABCD, fields stable throughout, DONE 7 cycles after IDLE.
- LW addr 0x101; SH addr 0x3; funct3=011; read+write together → each gives o_fault=1, o_stall=0, o_memValid never asserted.
- TIMEOUT_CYCLES=4, load with ready=1 then no response → o_fault in DONE, loadData 0, then IDLE.
- Assert i_arst while in RESPONSE, then pulse i_memRespValid → all outputs 0, state IDLE, response ignored.
